// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner:
//   - repeat FSM state encoding
//   - counter-width helper
//   - default timing constants for a 25 MHz system clock
package button_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2,
    RPT_HOLD   = 2'd3
  } rpt_state_e;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned DEBOUNCE_LIMIT_DEF = 25000;     // 1 ms
  localparam int unsigned REPEAT_DELAY_DEF   = 12500000;  // 0.5 s
  localparam int unsigned REPEAT_RATE_DEF    = 2500000;   // 100 ms

  // Bits needed to hold values 0..max_val, i.e. clog2(max_val+1), minimum 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    for (int unsigned w = 1; w < 32; w++) begin
      if ((64'd1 << w) > 64'(max_val)) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned input channel: synchroniser, debounce counter and
// auto-repeat FSM. All outputs are registered.
//   i_Clk, i_Rst     clock, async active-high reset
//   i_Bouncy         raw asynchronous switch pin
//   i_Repeat_En      auto-repeat enable (synchronous)
//   i_Force_Hold     park the repeat FSM in HOLD (chord lockout)
//   o_Level          debounced level
//   o_Rise/o_Fall    one-cycle pulse in the first cycle of a new level
//   o_Repeat         one-cycle auto-repeat pulse
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
  parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE    = REPEAT_RATE_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Bouncy,
  input  logic i_Repeat_En,
  input  logic i_Force_Hold,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Repeat
);

  localparam int unsigned DB_W  = cnt_width(DEBOUNCE_LIMIT);
  localparam int unsigned TMR_W =
    cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d, fall_q, fall_d, rep_q, rep_d;
  rpt_state_e             state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], i_Bouncy};
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_out != level_q) begin
      if (db_cnt_q == DB_LAST) level_d = ~level_q;
      else                     db_cnt_d = db_cnt_q + DB_W'(1);
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Pulses are computed one cycle early so they line up with the
  // registered level they belong to.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rep_d   = 1'b0;
    if (fall_d) begin
      state_d = RPT_IDLE;
      tmr_d   = '0;
    end else if (i_Force_Hold && (state_q != RPT_IDLE || rise_d)) begin
      state_d = RPT_HOLD;
      tmr_d   = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (rise_d) begin
            state_d = i_Repeat_En ? RPT_DELAY : RPT_HOLD;
            tmr_d   = '0;
          end
        end
        RPT_DELAY: begin
          if (!i_Repeat_En) begin
            state_d = RPT_HOLD;
          end else if (tmr_q == DELAY_LAST) begin
            rep_d   = 1'b1;
            state_d = RPT_REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (!i_Repeat_En) begin
            state_d = RPT_HOLD;
          end else if (tmr_q == RATE_LAST) begin
            rep_d = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        RPT_HOLD: ;
        default:  state_d = RPT_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      rep_q    <= 1'b0;
      state_q  <= RPT_IDLE;
      tmr_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rep_q    <= rep_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
    end
  end

  assign o_Level  = level_q;
  assign o_Rise   = rise_q;
  assign o_Fall   = fall_q;
  assign o_Repeat = rep_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel button conditioner: per-channel debounce/auto-repeat plus a
// masked chord detector with movement lockout.
//   i_Clk, i_Rst     clock, async active-high reset
//   i_Bouncy         raw switch pins
//   i_Repeat_En      per-channel auto-repeat enable
//   o_Level          debounced levels
//   o_Press          press / repeat pulses (gated by lockout)
//   o_Release        release pulses (gated by lockout)
//   o_Chord          all CHORD_MASK channels debounced-high
//   o_Chord_Press    one-cycle pulse on chord entry
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned       NUM_CH         = 4,
  parameter int unsigned       SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned       DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
  parameter int unsigned       REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int unsigned       REPEAT_RATE    = REPEAT_RATE_DEF,
  parameter logic [NUM_CH-1:0] CHORD_MASK     = {NUM_CH{1'b1}}
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Bouncy,
  input  logic [NUM_CH-1:0] i_Repeat_En,
  output logic [NUM_CH-1:0] o_Level,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic              o_Chord,
  output logic              o_Chord_Press
);

  localparam logic CHORD_EN = (CHORD_MASK != '0);

  logic [NUM_CH-1:0] rise, fall, rep, locked_mask;
  logic              chord_now, chord_entry, locked;
  logic              lockout_q, lockout_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    button_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_ch (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_Bouncy    (i_Bouncy[ch]),
      .i_Repeat_En (i_Repeat_En[ch]),
      .i_Force_Hold(locked_mask[ch]),
      .o_Level     (o_Level[ch]),
      .o_Rise      (rise[ch]),
      .o_Fall      (fall[ch]),
      .o_Repeat    (rep[ch])
    );
  end

  // Lockout stays set until every masked channel is released, so a chord
  // entry (chord_now while not locked) is always a true 0->1 transition and
  // wobbling inside the mask cannot re-trigger it. The entry cycle itself is
  // treated as locked so the completing press and any due repeat are eaten.
  always_comb begin
    chord_now   = CHORD_EN && ((o_Level & CHORD_MASK) == CHORD_MASK);
    chord_entry = chord_now && !lockout_q;
    locked      = lockout_q || chord_entry;
    locked_mask = locked ? CHORD_MASK : '0;

    lockout_d = lockout_q;
    if (chord_entry)                           lockout_d = 1'b1;
    else if ((o_Level & CHORD_MASK) == '0)     lockout_d = 1'b0;

    o_Chord       = chord_now;
    o_Chord_Press = chord_entry;
    o_Press       = (rise | rep) & ~locked_mask;
    o_Release     = fall & ~locked_mask;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) lockout_q <= 1'b0;
    else       lockout_q <= lockout_d;
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bouncy, rep_en, bouncy_nc, rep_en_nc;
  logic [3:0] level, press, rel, level_nc, press_nc, rel_nc;
  logic       chord, chord_press, chord_nc, chord_press_nc;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  // Scoreboard: {cycle[23:0], kind[3:0], ch[3:0]}; kind 0=press 1=release 2=chord
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  bit mon_on  = 1'b0;
  bit mon_sel = 1'b0;

  button_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .CHORD_MASK(4'b1111)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Bouncy(bouncy), .i_Repeat_En(rep_en),
    .o_Level(level), .o_Press(press), .o_Release(rel),
    .o_Chord(chord), .o_Chord_Press(chord_press)
  );

  button_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .CHORD_MASK(4'b0000)
  ) dut_nc (
    .i_Clk(clk), .i_Rst(rst), .i_Bouncy(bouncy_nc), .i_Repeat_En(rep_en_nc),
    .o_Level(level_nc), .o_Press(press_nc), .o_Release(rel_nc),
    .o_Chord(chord_nc), .o_Chord_Press(chord_press_nc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] ev(input int unsigned c, input int unsigned kind,
                                     input int unsigned ch);
    return {c[23:0], kind[3:0], ch[3:0]};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 4; i++) begin
        if (!mon_sel ? press[i] : press_nc[i]) obs_q.push_back(ev(cyc, 0, i));
        if (!mon_sel ? rel[i]   : rel_nc[i])   obs_q.push_back(ev(cyc, 1, i));
      end
      if (!mon_sel ? chord_press : chord_press_nc) obs_q.push_back(ev(cyc, 2, 0));
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; bouncy = 4'b1111; rep_en = '0; bouncy_nc = 4'b1111; rep_en_nc = '0;
    #1;
    checks++;
    if ({level, press, rel, chord, chord_press} !== '0) begin
      failures++;
      $display("FAIL reset_pre_clock: got %b, expected 0", {level, press, rel, chord, chord_press});
    end
    tick(10);
    checks++;
    if ({level, press, rel, chord, chord_press} !== '0) begin
      failures++;
      $display("FAIL reset_held: got %b, expected 0", {level, press, rel, chord, chord_press});
    end
    checks++;
    if ({level_nc, press_nc, rel_nc, chord_nc, chord_press_nc} !== '0) begin
      failures++;
      $display("FAIL reset_held_nc: got %b, expected 0",
               {level_nc, press_nc, rel_nc, chord_nc, chord_press_nc});
    end
    bouncy = '0; bouncy_nc = '0;
    tick(2);
    rst = 1'b0;
    tick(10);
    mon_on = 1'b1;
  endtask

  task automatic test_bounce;
    logic [31:0] e, o;
    int unsigned t0;
    obs_q.delete(); exp_q.delete(); mon_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bouncy[0] = ~bouncy[0];
      tick(2);
    end
    bouncy[0] = 1'b1; t0 = cyc;
    exp_q.push_back(ev(t0 + 6, 0, 0));
    tick(5);
    checks++;
    if (level[0] !== 1'b0) begin
      failures++; $display("FAIL bounce_level_early: got %b, expected 0", level[0]);
    end
    tick(1);
    checks++;
    if (level[0] !== 1'b1) begin
      failures++; $display("FAIL bounce_level_rise: got %b, expected 1", level[0]);
    end
    tick(10);
    bouncy[0] = 1'b0; t0 = cyc;
    exp_q.push_back(ev(t0 + 6, 1, 0));
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL bounce_event: got none, expected cyc=%0d kind=%0d ch=%0d", e[31:8], e[7:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL bounce_event: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=%0d ch=%0d", o[31:8], o[7:4], o[3:0], e[31:8], e[7:4], e[3:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL bounce_extra: got %0d extra (first cyc=%0d kind=%0d ch=%0d), expected 0", obs_q.size(), o[31:8], o[7:4], o[3:0]);
    end
  endtask

  task automatic test_repeat;
    logic [31:0] e, o;
    int unsigned p;
    obs_q.delete(); exp_q.delete(); mon_sel = 1'b0;
    rep_en[1] = 1'b1;
    tick(1);
    bouncy[1] = 1'b1; p = cyc + 6;
    exp_q.push_back(ev(p, 0, 1));
    for (int unsigned c = p + 10; c < p + 30; c += 3) exp_q.push_back(ev(c, 0, 1));
    tick(30);
    bouncy[1] = 1'b0;
    exp_q.push_back(ev(p + 30, 1, 1));
    tick(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL repeat_event: got none, expected cyc=%0d kind=%0d ch=%0d", e[31:8], e[7:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL repeat_event: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=%0d ch=%0d", o[31:8], o[7:4], o[3:0], e[31:8], e[7:4], e[3:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL repeat_extra: got %0d extra (first cyc=%0d kind=%0d ch=%0d), expected 0", obs_q.size(), o[31:8], o[7:4], o[3:0]);
    end
    rep_en[1] = 1'b0;
  endtask

  task automatic test_repeat_disable;
    logic [31:0] e, o;
    int unsigned p;
    obs_q.delete(); exp_q.delete(); mon_sel = 1'b0;
    rep_en[2] = 1'b1;
    tick(1);
    bouncy[2] = 1'b1; p = cyc + 6;
    exp_q.push_back(ev(p, 0, 2));
    exp_q.push_back(ev(p + 10, 0, 2));
    tick(p + 11 - cyc);
    rep_en[2] = 1'b0;
    tick(3);
    rep_en[2] = 1'b1;   // HOLD must not resume repeating
    tick(p + 30 - cyc);
    bouncy[2] = 1'b0;
    exp_q.push_back(ev(p + 36, 1, 2));
    tick(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL rptdis_event: got none, expected cyc=%0d kind=%0d ch=%0d", e[31:8], e[7:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL rptdis_event: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=%0d ch=%0d", o[31:8], o[7:4], o[3:0], e[31:8], e[7:4], e[3:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL rptdis_extra: got %0d extra (first cyc=%0d kind=%0d ch=%0d), expected 0", obs_q.size(), o[31:8], o[7:4], o[3:0]);
    end
    rep_en[2] = 1'b0;
  endtask

  task automatic test_chord;
    logic [31:0] e, o;
    int unsigned d0;
    obs_q.delete(); exp_q.delete(); mon_sel = 1'b0;
    tick(1);
    rep_en = 4'b1000;
    d0 = cyc;
    bouncy[0] = 1'b1; exp_q.push_back(ev(d0 + 6, 0, 0));
    tick(20);
    bouncy[1] = 1'b1; exp_q.push_back(ev(d0 + 26, 0, 1));
    tick(20);
    bouncy[2] = 1'b1; exp_q.push_back(ev(d0 + 46, 0, 2));
    tick(20);
    bouncy[3] = 1'b1; exp_q.push_back(ev(d0 + 66, 2, 0));
    tick(5);
    checks++;
    if (chord !== 1'b0) begin
      failures++; $display("FAIL chord_before: got %b, expected 0", chord);
    end
    tick(1);
    checks++;
    if ({chord, chord_press, press} !== 6'b11_0000) begin
      failures++; $display("FAIL chord_entry: got chord/press/o_Press=%b, expected 110000", {chord, chord_press, press});
    end
    rep_en = 4'b1111;
    tick(14);
    bouncy[0] = 1'b0;
    tick(10);
    bouncy[0] = 1'b1;
    tick(10);
    checks++;
    if (chord !== 1'b1) begin
      failures++; $display("FAIL chord_reform: got %b, expected 1", chord);
    end
    bouncy = '0; rep_en = '0;
    tick(30);
    bouncy[1] = 1'b1; exp_q.push_back(ev(d0 + 136, 0, 1));
    tick(20);
    bouncy[1] = 1'b0; exp_q.push_back(ev(d0 + 156, 1, 1));
    tick(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL chord_event: got none, expected cyc=%0d kind=%0d ch=%0d", e[31:8], e[7:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL chord_event: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=%0d ch=%0d", o[31:8], o[7:4], o[3:0], e[31:8], e[7:4], e[3:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL chord_extra: got %0d extra (first cyc=%0d kind=%0d ch=%0d), expected 0", obs_q.size(), o[31:8], o[7:4], o[3:0]);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e, o;
    int unsigned p, q;
    obs_q.delete(); exp_q.delete(); mon_sel = 1'b0;
    rep_en[1] = 1'b1;
    tick(1);
    bouncy[1] = 1'b1; p = cyc + 6;
    exp_q.push_back(ev(p, 0, 1));
    exp_q.push_back(ev(p + 10, 0, 1));
    exp_q.push_back(ev(p + 13, 0, 1));
    tick(p + 16 - cyc);
    checks++;
    if (press[1] !== 1'b1) begin
      failures++; $display("FAIL areset_pre_press: got %b, expected 1", press[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({level, press, rel, chord, chord_press} !== '0) begin
      failures++; $display("FAIL areset_outputs: got %b, expected 0", {level, press, rel, chord, chord_press});
    end
    #1;
    rst = 1'b0;
    q = cyc;
    exp_q.push_back(ev(q + 6, 0, 1));
    tick(8);
    bouncy[1] = 1'b0;
    exp_q.push_back(ev(q + 14, 1, 1));
    tick(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL areset_event: got none, expected cyc=%0d kind=%0d ch=%0d", e[31:8], e[7:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL areset_event: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=%0d ch=%0d", o[31:8], o[7:4], o[3:0], e[31:8], e[7:4], e[3:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL areset_extra: got %0d extra (first cyc=%0d kind=%0d ch=%0d), expected 0", obs_q.size(), o[31:8], o[7:4], o[3:0]);
    end
    rep_en[1] = 1'b0;
  endtask

  task automatic test_chord_disabled;
    logic [31:0] e, o;
    int unsigned d;
    obs_q.delete(); exp_q.delete(); mon_sel = 1'b1;
    tick(1);
    bouncy_nc = 4'b1111; d = cyc;
    for (int unsigned ch = 0; ch < 4; ch++) exp_q.push_back(ev(d + 6, 0, ch));
    tick(10);
    checks++;
    if ({level_nc, chord_nc} !== 5'b1111_0) begin
      failures++; $display("FAIL nochord_level: got level/chord=%b, expected 11110", {level_nc, chord_nc});
    end
    bouncy_nc = '0;
    for (int unsigned ch = 0; ch < 4; ch++) exp_q.push_back(ev(d + 16, 1, ch));
    tick(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL nochord_event: got none, expected cyc=%0d kind=%0d ch=%0d", e[31:8], e[7:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL nochord_event: got cyc=%0d kind=%0d ch=%0d, expected cyc=%0d kind=%0d ch=%0d", o[31:8], o[7:4], o[3:0], e[31:8], e[7:4], e[3:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL nochord_extra: got %0d extra (first cyc=%0d kind=%0d ch=%0d), expected 0", obs_q.size(), o[31:8], o[7:4], o[3:0]);
    end
    mon_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_repeat();
    test_repeat_disable();
    test_chord();
    test_async_reset();
    test_chord_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised N-channel input conditioner that replaces the per-switch debounce instances in the game top.
- Each channel gets a synchroniser, a debouncer, one-cycle press/release pulses and optional auto-repeat.
- A masked "chord" detector produces a clean start/pause event and locks out movement pulses from the chord buttons until they are released.
- Sits between the board switch pins and frogger_game.

Parameters:
- NUM_CH, 4, number of input channels.
- SYNC_STAGES, 2, synchroniser flip-flops per channel (min 2).
- DEBOUNCE_LIMIT, 25000, consecutive stable cycles required to accept a new level (min 2).
- REPEAT_DELAY, 12500000, cycles from the initial press to the first repeat pulse (0.5 s at 25 MHz).
- REPEAT_RATE, 2500000, cycles between subsequent repeat pulses (100 ms).
- CHORD_MASK, {NUM_CH{1'b1}}, channels forming the chord. All-zero disables the chord.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Bouncy  in  NUM_CH  raw switch pins, asynchronous.
- i_Repeat_En  in  NUM_CH  per-channel auto-repeat enable, synchronous.
- o_Level  out  NUM_CH  debounced level.
- o_Press  out  NUM_CH  one-cycle pulse on accepted press and on each repeat.
- o_Release  out  NUM_CH  one-cycle pulse on accepted release.
- o_Chord  out  1  high while all CHORD_MASK channels are debounced-high.
- o_Chord_Press  out  1  one-cycle pulse on chord entry.

Behaviour:
- **Reset.** Asynchronous and active-high. While i_Rst is high, all outputs, synchronisers, counters and FSMs are 0/IDLE, independent of the clock. A button held through reset is seen as a new press once reset deasserts.
- **Synchroniser.** SYNC_STAGES flops per channel; the sync output is the last flop.
- **Debounce.**
  - The counter increments each cycle that sync differs from o_Level.
  - It clears on any cycle where sync equals o_Level.
  - On the DEBOUNCE_LIMIT-th consecutive differing cycle, o_Level flips on that edge and the counter clears.
  - Pin-to-o_Level latency is exactly SYNC_STAGES+DEBOUNCE_LIMIT cycles.
  - Counter width is clog2(DEBOUNCE_LIMIT+1).
- **Pulses.**
  - o_Press asserts in the same cycle o_Level rises; o_Release asserts in the same cycle it falls.
  - Both are single-cycle and never asserted together on one channel.
- **Repeat FSM per channel: IDLE, DELAY, REPEAT, HOLD.**
  - IDLE, on rise: go to DELAY if i_Repeat_En[ch], otherwise HOLD; the timer clears.
  - DELAY: after REPEAT_DELAY cycles, pulse o_Press and go to REPEAT with the timer cleared.
  - REPEAT: pulse o_Press every REPEAT_RATE cycles.
  - DELAY/REPEAT with i_Repeat_En[ch] low: go to HOLD with no pulse in that cycle.
  - Any state, on fall: go to IDLE.
  - Timer width is clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- **Chord.**
  - chord_now = (o_Level & CHORD_MASK) == CHORD_MASK, with CHORD_MASK != 0.
  - o_Chord = chord_now, registered with o_Level (same cycle).
  - o_Chord_Press pulses on the 0->1 transition of chord_now.
- **Lockout.**
  - Set on chord entry; cleared when (o_Level & CHORD_MASK) == 0.
  - While set, masked channels produce no o_Press and no o_Release, and their FSMs are forced to HOLD.
  - Unmasked channels are unaffected.
  - Presses emitted before chord completion are not retracted.
- **Simultaneous events.**
  - When the last chord channel rises in the same cycle it completes the chord, o_Chord_Press wins and that channel's o_Press is suppressed.
  - A repeat pulse due in the chord-entry cycle is suppressed.
  - A new press after lockout clears behaves as from IDLE.
  - Re-entering the chord requires lockout to clear first, so there is no double o_Chord_Press while buttons wobble inside the mask.

Decomposition:
- Shared package button_pkg:
  - repeat state encoding (IDLE=0, DELAY=1, REPEAT=2, HOLD=3);
  - a clog2-based counter-width function;
  - default timing constants for 25 MHz.
- Sub-module button_channel: synchroniser, debounce counter and repeat FSM for one channel, with a force_hold input and raw rise/fall/repeat outputs.
- The top of this block instantiates NUM_CH button_channel instances via generate and implements chord detection, lockout and pulse gating.

Test Plan:
All scenarios use NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_RATE=3, CHORD_MASK=4'b1111.
- **Bounce:** toggle i_Bouncy[0] every 2 cycles for 20 cycles, then hold 1 (t0 = final edge) -> o_Level[0] rises at t0+6; exactly one o_Press[0]; no o_Release[0].
- **Repeat:** hold ch1 with i_Repeat_En[1]=1, pressed at cycle P -> o_Press[1] at P, P+10, P+13, P+16…; on release, one o_Release[1] and no further presses.
- **Repeat disable:** drop i_Repeat_En[2] at P+11 -> no pulse at P+13 or later; FSM in HOLD; o_Release[2] on release.
- **Chord:** press ch0..ch3 staggered 20 cycles apart -> o_Press[0..2] once each; o_Chord_Press once when ch3 settles with no o_Press[3]; no repeats while held; no o_Release for ch0–3. After all are released, pressing ch1 -> o_Press[1].
- **Async reset:** pulse i_Rst mid-REPEAT between clock edges -> all outputs 0 before the next edge. With the button still held, o_Press fires 6 cycles after reset release.
- **Chord disabled:** CHORD_MASK=0, press all four buttons -> o_Chord and o_Chord_Press stay 0; four individual o_Press pulses.
